user_tspi_ctrl: RTL and testbench

USER_TSPI_CTRL -- requirements
Module: user_tspi_ctrl

---
 rtl/user_pkg.sv | 33 +++
 rtl/user_tspi_clkgen.sv | 43 ++++
 rtl/user_tspi_ctrl.sv | 117 +++++++++++
 tb/tb_user_tspi_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/user_pkg.sv
// Shared constants and FSM encoding for the transparent SPI read window.
`timescale 1ns/1ps
package user_pkg;

   localparam logic [7:0] TspiCmdRead     = 8'h03;
   localparam logic [7:0] TspiCmdFastRead = 8'h0B;

   typedef enum logic [2:0] {
      TSPI_IDLE     = 3'd0,
      TSPI_CS_SETUP = 3'd1,
      TSPI_CMD      = 3'd2,
      TSPI_ADDR     = 3'd3,
      TSPI_DUMMY    = 3'd4,
      TSPI_DATA     = 3'd5,
      TSPI_RESP     = 3'd6,
      TSPI_WERR     = 3'd7
   } tspi_state_e;

   // Index of the final bit of each shifting phase (bits are counted from 0).
   function automatic logic [4:0] tspi_last_bit(input tspi_state_e s);
      logic [4:0] last;
      last = 5'd0;
      case (s)
         TSPI_CMD:   last = 5'd7;
         TSPI_ADDR:  last = 5'd23;
         TSPI_DUMMY: last = 5'd7;
         TSPI_DATA:  last = 5'd31;
         default:    last = 5'd0;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/user_tspi_clkgen.sv
// Mode-0 SCK generator: low half then high half, ClkDiv clk_i cycles each.
// Latency: rise_o/fall_o flag the cycle whose closing edge moves SCK.
// Backpressure: none; en_i low parks SCK low and restarts the bit.
`timescale 1ns/1ps
module user_tspi_clkgen #(
   parameter int unsigned ClkDiv = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic sck_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [8:0] HalfEnd = 9'(ClkDiv - 1);
   localparam logic [8:0] FullEnd = 9'(2 * ClkDiv - 1);

   logic [8:0] r_cnt;
   logic       r_sck;

   assign rise_o = en_i && (r_cnt == HalfEnd);
   assign fall_o = en_i && (r_cnt == FullEnd);
   assign sck_o  = r_sck;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
         r_sck <= 1'b0;
      end else if (!en_i) begin
         r_cnt <= '0;
         r_sck <= 1'b0;
      end else begin
         r_cnt <= fall_o ? 9'd0 : r_cnt + 9'd1;
         if (rise_o) begin
            r_sck <= 1'b1;
         end else if (fall_o) begin
            r_sck <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/user_tspi_ctrl.sv
// OBI-to-SPI read bridge; USER_TSPI_FAST_READ_EN selects 0x0B with 8 dummy SCKs.
// Latency: rvalid 2+128*ClkDiv cycles after grant (2+144*ClkDiv fast), writes error next cycle.
// Backpressure: gnt_o only in IDLE, so one transfer in flight at a time.
`timescale 1ns/1ps
module user_tspi_ctrl
   import user_pkg::*;
#(
   parameter int unsigned ClkDiv = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        spi_sck_o,
   output logic        spi_csn_o,
   output logic        spi_mosi_o,
   input  logic        spi_miso_i,
   output logic        busy_o
);

`ifdef USER_TSPI_FAST_READ_EN
   localparam logic [7:0]  CmdOp     = TspiCmdFastRead;
   localparam tspi_state_e AfterAddr = TSPI_DUMMY;
`else
   localparam logic [7:0]  CmdOp     = TspiCmdRead;
   localparam tspi_state_e AfterAddr = TSPI_DATA;
`endif

   tspi_state_e r_state;
   tspi_state_e w_state_nxt;
   logic [31:0] r_tx;
   logic [31:0] r_rx;
   logic [31:0] r_rdata;
   logic [4:0]  r_bit;
   logic        w_shift;
   logic        w_rise;
   logic        w_fall;
   logic        w_last;
   logic        w_unused;

   assign w_unused = ^{be_i, wdata_i, addr_i[31:24], addr_i[1:0]};

   assign w_shift = (r_state == TSPI_CMD) || (r_state == TSPI_ADDR) ||
                    (r_state == TSPI_DUMMY) || (r_state == TSPI_DATA);
   assign w_last  = (r_bit == tspi_last_bit(r_state));

   user_tspi_clkgen #(
      .ClkDiv (ClkDiv)
   ) u_clkgen (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (w_shift),
      .sck_o  (spi_sck_o),
      .rise_o (w_rise),
      .fall_o (w_fall)
   );

   // Reset gates the grant so a request held through reset is not granted early.
   assign gnt_o      = rst_ni && (r_state == TSPI_IDLE) && req_i;
   assign busy_o     = (r_state != TSPI_IDLE);
   assign rvalid_o   = (r_state == TSPI_RESP) || (r_state == TSPI_WERR);
   assign err_o      = (r_state == TSPI_WERR);
   assign rdata_o    = (r_state == TSPI_WERR) ? 32'd0 : r_rdata;
   assign spi_csn_o  = !(w_shift || (r_state == TSPI_CS_SETUP));
   assign spi_mosi_o = r_tx[31];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         TSPI_IDLE:     if (req_i) w_state_nxt = we_i ? TSPI_WERR : TSPI_CS_SETUP;
         TSPI_CS_SETUP: w_state_nxt = TSPI_CMD;
         TSPI_CMD:      if (w_fall && w_last) w_state_nxt = TSPI_ADDR;
         TSPI_ADDR:     if (w_fall && w_last) w_state_nxt = AfterAddr;
         TSPI_DUMMY:    if (w_fall && w_last) w_state_nxt = TSPI_DATA;
         TSPI_DATA:     if (w_fall && w_last) w_state_nxt = TSPI_RESP;
         TSPI_RESP:     w_state_nxt = TSPI_IDLE;
         TSPI_WERR:     w_state_nxt = TSPI_IDLE;
         default:       w_state_nxt = TSPI_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= TSPI_IDLE;
         r_tx    <= '0;
         r_rx    <= '0;
         r_rdata <= '0;
         r_bit   <= '0;
      end else begin
         r_state <= w_state_nxt;
         // Opcode+address shift out MSB first; zeros back-fill so dummy/data phases send 0.
         if (gnt_o && !we_i) begin
            r_tx <= {CmdOp, addr_i[23:2], 2'b00};
         end else if (w_shift && w_fall) begin
            r_tx <= {r_tx[30:0], 1'b0};
         end
         if (w_shift && w_fall) begin
            r_bit <= w_last ? 5'd0 : r_bit + 5'd1;
         end
         if ((r_state == TSPI_DATA) && w_rise) begin
            r_rx <= {r_rx[30:0], spi_miso_i};
         end
         // First byte on the wire lands in the low byte of the OBI word.
         if ((r_state == TSPI_DATA) && w_fall && w_last) begin
            r_rdata <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
         end
      end
   end

endmodule

// File: tb/tb_user_tspi_ctrl.sv
// Randomized bench for user_tspi_ctrl with a bit-level SPI flash model.
`timescale 1ns/1ps
module tb_user_tspi_ctrl;

`ifdef USER_TSPI_FAST_READ_EN
   localparam int         CLK_DIV = 1;
   localparam int         HDR     = 40;
   localparam logic [7:0] OPC     = 8'h0B;
   localparam int         LAT     = 2 + 144 * CLK_DIV;
`else
   localparam int         CLK_DIV = 2;
   localparam int         HDR     = 32;
   localparam logic [7:0] OPC     = 8'h03;
   localparam int         LAT     = 2 + 128 * CLK_DIV;
`endif
   localparam int TOTAL = HDR + 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = 4'hF;
   logic [31:0] wdata = '0;
   logic        gnt_o, rvalid_o, err_o, busy_o;
   logic [31:0] rdata_o;
   logic        spi_sck_o, spi_csn_o, spi_mosi_o;
   logic        miso = 1'b0;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int gnt_busy = 0;
   int rv_count = 0;

   user_tspi_ctrl #(.ClkDiv(CLK_DIV)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_i      (req),
      .gnt_o      (gnt_o),
      .addr_i     (addr),
      .we_i       (we),
      .be_i       (be),
      .wdata_i    (wdata),
      .rvalid_o   (rvalid_o),
      .rdata_o    (rdata_o),
      .err_o      (err_o),
      .spi_sck_o  (spi_sck_o),
      .spi_csn_o  (spi_csn_o),
      .spi_mosi_o (spi_mosi_o),
      .spi_miso_i (miso),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rvalid_o) rv_count <= rv_count + 1;
   end

   always @(negedge clk) begin
      if (rst_n && busy_o && gnt_o) gnt_busy = gnt_busy + 1;
   end

   // Flash model: samples MOSI on SCK rise, presents the next read bit after SCK fall.
   logic [31:0] flash_data = '0;
   logic [71:0] mosi_cap = '0;
   int          rx_n = 0;
   int          csn_falls = 0;
   int          sl_k = 0;
   logic        prev_sck = 1'b0;
   logic        prev_csn = 1'b1;

   always @(spi_sck_o or spi_csn_o) begin
      if (prev_csn === 1'b1 && spi_csn_o === 1'b0) begin
         rx_n      = 0;
         mosi_cap  = '0;
         miso      = 1'b0;
         csn_falls = csn_falls + 1;
      end
      if (spi_csn_o === 1'b0 && prev_sck === 1'b0 && spi_sck_o === 1'b1) begin
         mosi_cap = {mosi_cap[70:0], spi_mosi_o};
         rx_n     = rx_n + 1;
      end
      if (spi_csn_o === 1'b0 && prev_sck === 1'b1 && spi_sck_o === 1'b0) begin
         sl_k = rx_n - HDR;
         if (sl_k >= 0 && sl_k < 32) miso = flash_data[31 - sl_k];
      end
      prev_sck = spi_sck_o;
      prev_csn = spi_csn_o;
   end

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_gnt(output int g);
      g = -1;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (gnt_o === 1'b1) begin
            g = cyc;
            break;
         end
         @(negedge clk);
      end
      chk("gnt_seen", 72'(g >= 0), 72'(1));
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] stream, input bit hold,
                          output int g, output int r);
      logic [31:0] exp_rd;
      logic [71:0] exp_mosi;
      flash_data = stream;
      addr = a;
      we   = 1'b0;
      req  = 1'b1;
      wait_gnt(g);
      @(negedge clk);
      if (!hold) req = 1'b0;
      chk("busy_after_gnt", 72'(busy_o), 72'(1));
      r = -1;
      for (int i = 0; i < 2000; i++) begin
         if (rvalid_o === 1'b1) begin
            r = cyc;
            break;
         end
         @(negedge clk);
      end
      exp_rd   = {stream[7:0], stream[15:8], stream[23:16], stream[31:24]};
      exp_mosi = 72'({OPC, a[23:2], 2'b00}) << (TOTAL - 32);
      chk("rd_latency", 72'(r - g), 72'(LAT));
      chk("rd_err", 72'(err_o), 72'(0));
      chk("rd_data", 72'(rdata_o), 72'(exp_rd));
      chk("mosi_stream", mosi_cap, exp_mosi);
      chk("sck_bits", 72'(rx_n), 72'(TOTAL));
      chk("csn_in_resp", 72'(spi_csn_o), 72'(1));
      @(negedge clk);
      chk("rvalid_pulse", 72'(rvalid_o), 72'(0));
      chk("rd_hold", 72'(rdata_o), 72'(exp_rd));
      chk("csn_after_resp", 72'(spi_csn_o), 72'(1));
   endtask

   int g, r, g2, r2, f0, rv0;

   initial begin
      #1;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 72'(gnt_o), 72'(0));
      chk("rst_rvalid", 72'(rvalid_o), 72'(0));
      chk("rst_err", 72'(err_o), 72'(0));
      chk("rst_rdata", 72'(rdata_o), 72'(0));
      chk("rst_csn", 72'(spi_csn_o), 72'(1));
      chk("rst_sck", 72'(spi_sck_o), 72'(0));
      chk("rst_mosi", 72'(spi_mosi_o), 72'(0));
      chk("rst_busy", 72'(busy_o), 72'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed reads: bytes 11,22,33,44 on the wire.
      do_read(32'h4000_0104, 32'h1122_3344, 1'b0, g, r);
      do_read(32'h4000_0003, 32'hA1B2_C3D4, 1'b0, g, r);

      // Write: immediate error response, no SPI traffic.
      f0 = csn_falls;
      addr = 32'h4000_0000;
      we = 1'b1;
      wdata = $urandom;
      req = 1'b1;
      wait_gnt(g);
      @(negedge clk);
      req = 1'b0;
      we = 1'b0;
      chk("wr_rvalid", 72'(rvalid_o), 72'(1));
      chk("wr_err", 72'(err_o), 72'(1));
      chk("wr_rdata", 72'(rdata_o), 72'(0));
      chk("wr_csn", 72'(spi_csn_o), 72'(1));
      @(negedge clk);
      chk("wr_pulse", 72'(rvalid_o), 72'(0));
      repeat (4) @(negedge clk);
      chk("wr_no_spi", 72'(csn_falls - f0), 72'(0));

      // Back-to-back reads with req held across RESP.
      do_read($urandom, $urandom, 1'b1, g, r);
      do_read($urandom, $urandom, 1'b0, g2, r2);
      chk("b2b_gnt", 72'(g2 - r), 72'(1));

      // Reset during the address phase aborts without a response.
      flash_data = $urandom;
      addr = $urandom;
      req = 1'b1;
      wait_gnt(g);
      @(negedge clk);
      req = 1'b0;
      repeat (2 * CLK_DIV * 18) @(negedge clk);
      chk("pre_rst_busy", 72'(busy_o), 72'(1));
      chk("pre_rst_csn", 72'(spi_csn_o), 72'(0));
      rv0 = rv_count;
      rst_n = 1'b0;
      #1;
      chk("abort_csn", 72'(spi_csn_o), 72'(1));
      chk("abort_sck", 72'(spi_sck_o), 72'(0));
      chk("abort_busy", 72'(busy_o), 72'(0));
      chk("abort_rvalid", 72'(rvalid_o), 72'(0));
      chk("abort_mosi", 72'(spi_mosi_o), 72'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("abort_no_resp", 72'(rv_count - rv0), 72'(0));
      do_read($urandom, $urandom, 1'b0, g, r);

      // Random reads.
      for (int i = 0; i < 6; i++) begin
         do_read($urandom, $urandom, 1'b0, g, r);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      chk("gnt_while_busy", 72'(gnt_busy), 72'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
